// File: rtl/piso_rr_scheduler_pkg.sv
// Shared types and defaults for the round-robin parallel-in/serial-out scheduler.
package piso_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NCH   = 4;

    typedef enum logic {
        PS_IDLE  = 1'b0,
        PS_SHIFT = 1'b1
    } piso_state_e;

    // Channel-id width; a single channel still needs one bit to carry an id.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piso_rr_scheduler_arb.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping at NCH.
module rr_arbiter
    import piso_pkg::*;
#(
    parameter int  NCH  = DEF_NCH,
    localparam int CH_W = ch_w(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [CH_W-1:0] ptr,
    output logic [NCH-1:0]  gnt,
    output logic [CH_W-1:0] gnt_idx,
    output logic            gnt_vld
);

    logic [CH_W:0] idx;

    // One spare bit so ptr+i never overflows before the explicit wrap compare.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int i = 0; i < NCH; i++) begin
            idx = {1'b0, ptr} + (CH_W+1)'(i);
            if (idx >= (CH_W+1)'(NCH)) begin
                idx = idx - (CH_W+1)'(NCH);
            end
            if (!gnt_vld && req[idx[CH_W-1:0]]) begin
                gnt_vld               = 1'b1;
                gnt_idx               = idx[CH_W-1:0];
                gnt[idx[CH_W-1:0]]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/piso_rr_scheduler.sv
// Round-robin picks one parallel word and shifts it out LSB-first as a tagged frame.
// pready_o is only offered in IDLE; the serial side stalls in place while sready_i is low.
module piso_rr_scheduler
    import piso_pkg::*;
#(
    parameter int  WIDTH = DEF_WIDTH,
    parameter int  NCH   = DEF_NCH,
    localparam int CH_W  = ch_w(NCH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NCH*WIDTH-1:0] pdata_i,
    input  logic [NCH-1:0]       pvalid_i,
    output logic [NCH-1:0]       pready_o,
    output logic                 sdata_o,
    output logic                 svalid_o,
    input  logic                 sready_i,
    output logic                 sfirst_o,
    output logic                 slast_o,
    output logic [CH_W-1:0]      schan_o,
    output logic                 busy_o
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH-1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NCH-1);

    piso_state_e      state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CH_W-1:0]  chan_q;
    logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic             sfirst_q, slast_q;

    logic [NCH-1:0]   gnt;
    logic [CH_W-1:0]  gnt_idx;
    logic             gnt_vld;
    logic [WIDTH-1:0] pword [NCH];

    for (genvar k = 0; k < NCH; k++) begin : g_unpack
        assign pword[k] = pdata_i[k*WIDTH +: WIDTH];
    end

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req     (pvalid_i),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign bit_cnt_d = bit_cnt_q + CNT_W'(1);
    assign rr_ptr_d  = (chan_q == LAST_CH) ? '0 : chan_q + CH_W'(1);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= PS_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            chan_q    <= '0;
            rr_ptr_q  <= '0;
            sfirst_q  <= 1'b0;
            slast_q   <= 1'b0;
        end else begin
            case (state_q)
                PS_IDLE: begin
                    if (gnt_vld) begin
                        shreg_q   <= pword[gnt_idx];
                        chan_q    <= gnt_idx;
                        bit_cnt_q <= '0;
                        sfirst_q  <= 1'b1;
                        slast_q   <= 1'b0;
                        state_q   <= PS_SHIFT;
                    end
                end
                PS_SHIFT: begin
                    if (sready_i) begin
                        shreg_q  <= shreg_q >> 1;
                        sfirst_q <= 1'b0;
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_q <= '0;
                            slast_q   <= 1'b0;
                            rr_ptr_q  <= rr_ptr_d;
                            state_q   <= PS_IDLE;
                        end else begin
                            bit_cnt_q <= bit_cnt_d;
                            slast_q   <= (bit_cnt_d == LAST_BIT);
                        end
                    end
                end
            endcase
        end
    end

    // Gated by reset so no accept is offered while the block is held in reset.
    assign pready_o = (state_q == PS_IDLE && rst_i) ? gnt : '0;
    assign svalid_o = (state_q == PS_SHIFT);
    assign busy_o   = (state_q == PS_SHIFT);
    assign sdata_o  = shreg_q[0];
    assign sfirst_o = sfirst_q;
    assign slast_o  = slast_q;
    assign schan_o  = chan_q;

endmodule

// File: tb/tb_piso_rr_scheduler.sv
// Bench for piso_rr_scheduler: arbitration vectors, scoreboarded frames, stall/reset/wrap sequences.
module tb_piso_rr_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pdata = '0;
    logic [3:0]  pvalid = '0;
    logic [3:0]  pready;
    logic        sdata, svalid, sfirst, slast, busy;
    logic        sready = 1'b1;
    logic [1:0]  schan;

    logic [23:0] pdata3 = '0;
    logic [2:0]  pvalid3 = '0;
    logic [2:0]  pready3;
    logic        sdata3, svalid3, sfirst3, slast3, busy3;
    logic [1:0]  schan3;

    always #5 clk = ~clk;

    piso_rr_scheduler #(.WIDTH(8), .NCH(4)) dut (
        .clk_i(clk), .rst_i(rst), .pdata_i(pdata), .pvalid_i(pvalid), .pready_o(pready),
        .sdata_o(sdata), .svalid_o(svalid), .sready_i(sready), .sfirst_o(sfirst),
        .slast_o(slast), .schan_o(schan), .busy_o(busy)
    );

    piso_rr_scheduler #(.WIDTH(8), .NCH(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .pdata_i(pdata3), .pvalid_i(pvalid3), .pready_o(pready3),
        .sdata_o(sdata3), .svalid_o(svalid3), .sready_i(1'b1), .sfirst_o(sfirst3),
        .slast_o(slast3), .schan_o(schan3), .busy_o(busy3)
    );

    typedef struct {
        logic [1:0] ch;
        logic [7:0] word;
    } frame_t;

    typedef struct {
        logic [3:0]  pv;
        logic [31:0] pd;
        logic [3:0]  exp_rdy;
        logic [1:0]  exp_ch;
        logic [7:0]  exp_word;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    frame_t exp_q[$];
    int sof_cyc[$];
    int sof_ch[$];
    int frames_seen = 0;
    int beats = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Serial-side monitor: framing, stall stability and scoreboard compare.
    int         bitn = 0;
    logic [7:0] acc = '0;
    logic [1:0] fch = '0;
    logic       stalled = 1'b0;
    logic [5:0] snap = '0;
    always @(negedge clk) begin
        frame_t e;
        if (!rst) begin
            bitn    = 0;
            stalled = 1'b0;
        end else begin
            if (stalled) check("stall_hold", {sdata, sfirst, slast, svalid, schan}, snap);
            if (svalid) begin
                check("sfirst", sfirst, bitn == 0);
                check("slast", slast, bitn == 7);
                if (sready) begin
                    beats++;
                    if (bitn == 0) begin
                        fch = schan;
                        sof_cyc.push_back(cyc);
                        sof_ch.push_back(int'(schan));
                    end else begin
                        check("schan_const", schan, fch);
                    end
                    acc = {sdata, acc[7:1]};
                    if (bitn == 7) begin
                        bitn = 0;
                        frames_seen++;
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL frame_expected: got frame ch %0d word %0h, required none", fch, acc);
                        end else begin
                            e = exp_q.pop_front();
                            check("frame_ch", fch, e.ch);
                            check("frame_word", acc, e.word);
                        end
                    end else begin
                        bitn++;
                    end
                end
            end
            stalled = svalid && !sready;
            snap    = {sdata, sfirst, slast, svalid, schan};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; pvalid = '0; pdata = '0; sready = 1'b1; pvalid3 = '0; pdata3 = '0;
        tick();
        rst = 1'b1;
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (frames_seen < target && n < 200) begin
            tick();
            n++;
        end
        check("frames_done", frames_seen, target);
    endtask

    vec_t vecs[5];
    int   rr_order[5] = '{0, 1, 2, 3, 0};
    bit   bp_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int tgt, base, n, b0, busy_cyc;
        vecs[0] = '{pv: 4'b0001, pd: 32'h000000A5, exp_rdy: 4'b0001, exp_ch: 2'd0, exp_word: 8'hA5};
        vecs[1] = '{pv: 4'b0110, pd: 32'h005A3C00, exp_rdy: 4'b0010, exp_ch: 2'd1, exp_word: 8'h3C};
        vecs[2] = '{pv: 4'b1000, pd: 32'hF0000000, exp_rdy: 4'b1000, exp_ch: 2'd3, exp_word: 8'hF0};
        vecs[3] = '{pv: 4'b1100, pd: 32'h817E0000, exp_rdy: 4'b0100, exp_ch: 2'd2, exp_word: 8'h7E};
        vecs[4] = '{pv: 4'b1111, pd: 32'h44332211, exp_rdy: 4'b0001, exp_ch: 2'd0, exp_word: 8'h11};

        #2;
        check("rst_outputs", {pready, sdata, svalid, sfirst, slast, schan, busy}, 0);
        check("rst_busy3", {pready3, svalid3, busy3, schan3}, 0);

        // Grant from rr_ptr=0 after reset, first bit one cycle after accept.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            pvalid = vecs[v].pv;
            pdata  = vecs[v].pd;
            #1;
            check("vec_pready", pready, vecs[v].exp_rdy);
            exp_q.push_back('{ch: vecs[v].exp_ch, word: vecs[v].exp_word});
            tgt = frames_seen + 1;
            tick();
            pvalid = '0;
            check("vec_svalid", {svalid, busy, sfirst}, 3'b111);
            check("vec_first_bit", sdata, vecs[v].exp_word[0]);
            check("vec_schan", schan, vecs[v].exp_ch);
            check("vec_pready_shift", pready, 0);
            wait_frames(tgt);
        end

        // Round-robin fairness with all channels valid.
        do_reset();
        base = sof_cyc.size();
        tgt  = frames_seen + 5;
        pdata  = 32'h13121110;
        pvalid = 4'hF;
        for (int i = 0; i < 5; i++) exp_q.push_back('{ch: 2'(rr_order[i]), word: 8'(8'h10 + rr_order[i])});
        n = 0;
        while (sof_cyc.size() < base + 5 && n < 100) begin
            tick();
            n++;
        end
        pvalid = '0;
        wait_frames(tgt);
        check("rr_frame_count", sof_cyc.size() - base, 5);
        if (sof_cyc.size() >= base + 5) begin
            for (int i = 0; i < 5; i++) check("rr_order", sof_ch[base+i], rr_order[i]);
            for (int i = 0; i < 4; i++) check("rr_spacing", sof_cyc[base+i+1] - sof_cyc[base+i], 9);
        end

        // Backpressure on a ch2 frame.
        do_reset();
        pvalid = 4'b0100;
        pdata  = 32'h00C30000;
        exp_q.push_back('{ch: 2'd2, word: 8'hC3});
        tgt = frames_seen + 1;
        tick();
        pvalid = '0;
        b0 = beats;
        n = 0;
        while (frames_seen < tgt && n < 100) begin
            sready = bp_pat[n % 4];
            tick();
            n++;
        end
        sready = 1'b1;
        check("bp_frame_done", frames_seen, tgt);
        check("bp_beats", beats - b0, 8);

        // Request arriving mid-frame waits for the last beat.
        do_reset();
        pvalid = 4'b0010;
        pdata  = 32'h00009600;
        exp_q.push_back('{ch: 2'd1, word: 8'h96});
        tgt = frames_seen + 2;
        tick();
        pvalid = 4'b1000;
        pdata  = 32'hE7000000;
        busy_cyc = 0;
        n = 0;
        while (busy && n < 30) begin
            check("mid_pready_zero", pready, 0);
            busy_cyc++;
            tick();
            n++;
        end
        check("mid_busy_cycles", busy_cyc, 8);
        check("mid_pready_ch3", pready, 4'b1000);
        exp_q.push_back('{ch: 2'd3, word: 8'hE7});
        tick();
        pvalid = '0;
        check("mid_schan3", schan, 2'd3);
        wait_frames(tgt);

        // Reset at bit 4 of a ch2 frame.
        do_reset();
        pvalid = 4'b0100;
        pdata  = 32'h005A0000;
        tick();
        pvalid = '0;
        repeat (4) tick();
        check("rstmid_pre_bit4", {sdata, sfirst, schan, busy}, 5'b1_0_10_1);
        rst    = 1'b0;
        pvalid = 4'b1100;
        pdata  = 32'hBBAA0000;
        #1;
        check("rstmid_outputs", {pready, sdata, svalid, sfirst, slast, schan, busy}, 0);
        tick();
        rst = 1'b1;
        #1;
        check("rstmid_grant_ch2", pready, 4'b0100);
        exp_q.push_back('{ch: 2'd2, word: 8'hAA});
        tgt = frames_seen + 1;
        tick();
        pvalid = '0;
        check("rstmid_restart", {svalid, sfirst, schan}, 4'b1_1_10);
        wait_frames(tgt);

        // NCH=3: pointer wraps from 2 to 0.
        do_reset();
        pvalid3 = 3'b100;
        pdata3  = 24'hD20000;
        #1;
        check("wrap_first_grant", pready3, 3'b100);
        tick();
        pvalid3 = 3'b101;
        pdata3  = 24'hD2004B;
        check("wrap_schan2", {busy3, schan3}, 3'b1_10);
        n = 0;
        while (busy3 && n < 30) begin
            tick();
            n++;
        end
        check("wrap_busy_cycles", n, 8);
        check("wrap_grant_ch0", pready3, 3'b001);
        tick();
        pvalid3 = '0;
        check("wrap_schan0", {sfirst3, schan3, sdata3}, 4'b1_00_1);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, reached cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
